// File: rtl/vram_scan_controller_if.sv
// vram_scan_controller_if: VRAM port and pixel stream between the scan controller and its neighbours.
interface vram_scan_controller_if;
   logic [7:0] ram_address;
   logic [3:0] ram_data;
   logic       ram_wren;
   logic [3:0] ram_q;
   logic [3:0] pixel_data;
   logic [7:0] pixel_index;
   logic       pixel_valid;
   logic       pixel_ready;
   modport master (
      output ram_address, ram_data, ram_wren, pixel_data, pixel_index, pixel_valid,
      input  ram_q, pixel_ready
   );
   modport slave (
      input  ram_address, ram_data, ram_wren, pixel_data, pixel_index, pixel_valid,
      output ram_q, pixel_ready
   );
endinterface

// File: rtl/vram_scan_controller.sv
// vram_scan_controller: scans VRAM words out as a ready/valid pixel stream, or zero-fills them.
module vram_scan_controller #(
   parameter int WORDS = 256
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   frame_start,
   input  logic                   clear_req,
   output logic                   busy,
   output logic                   frame_done,
   vram_scan_controller_if.master bus
);
   typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, CAPTURE, PRESENT} state_t;
   localparam logic [7:0] LAST = 8'(WORDS - 1);
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d, idx_q, idx_d;
   logic [3:0] data_q, data_d;
   logic       pend_q, pend_d, valid_q, valid_d, done_q, done_d;
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         pend_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end
   // frame_start is remembered in every state; only starting a scan consumes it
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      pend_d  = pend_q | frame_start;
      valid_d = valid_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end else if (frame_start || pend_q) begin
               state_d = ISSUE;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end
         end
         CLEAR: begin
            state_d = (cnt_q == LAST) ? IDLE : CLEAR;
            cnt_d   = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
         end
         ISSUE: state_d = CAPTURE;
         CAPTURE: begin
            data_d  = bus.ram_q;
            idx_d   = cnt_q;
            valid_d = 1'b1;
            state_d = PRESENT;
         end
         PRESENT: begin
            if (valid_q && bus.pixel_ready) begin
               valid_d = 1'b0;
               done_d  = (cnt_q == LAST);
               state_d = (cnt_q == LAST) ? IDLE : ISSUE;
               cnt_d   = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   assign bus.ram_address = (state_q == CLEAR || state_q == ISSUE) ? cnt_q : 8'd0;
   assign bus.ram_wren    = (state_q == CLEAR);
   assign bus.ram_data    = 4'd0;
   assign bus.pixel_data  = data_q;
   assign bus.pixel_index = idx_q;
   assign bus.pixel_valid = valid_q;
   assign busy            = (state_q != IDLE);
   assign frame_done      = done_q;
endmodule
